// File: rtl/uart_baud_gen_if.sv
// Configuration and TX/RX timing signals exchanged between the UART
// register file / shift engines (master) and the baud generator (slave).
interface uart_baud_gen_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 cfg_div_we;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_err;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 tx_start;
  logic                 tx_done;
  logic                 tx_busy;
  logic                 tx_tick;
  logic                 rx_start;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 rx_os_tick;
  logic                 rx_mid_tick;

  modport master (
    output cfg_div_we, cfg_div, tx_start, tx_done, rx_start, rx_done,
    input  cfg_err, div_q, tx_busy, tx_tick, rx_busy, rx_os_tick, rx_mid_tick
  );

  modport slave (
    input  cfg_div_we, cfg_div, tx_start, tx_done, rx_start, rx_done,
    output cfg_err, div_q, tx_busy, tx_tick, rx_busy, rx_os_tick, rx_mid_tick
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Runtime-programmable UART baud generator with independent TX and RX
// channels. TX produces one strobe per bit; RX produces an oversample
// strobe plus a strobe at the centre of each bit.
module uart_baud_gen #(
  parameter int CLK_FRE    = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_baud_gen_if.slave  bus
);

  localparam int                   DIV_RST_INT = CLK_FRE / BAUD_RATE;
  localparam logic [DIV_WIDTH-1:0] DIV_RST     = DIV_WIDTH'(DIV_RST_INT);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN     = DIV_WIDTH'(4);
  localparam int                   OS_SHIFT    = (OVERSAMPLE == 16) ? 4 :
                                                 (OVERSAMPLE == 8)  ? 3 : 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_tx_state;
  state_t               w_tx_state_next;
  state_t               r_rx_state;
  state_t               w_rx_state_next;

  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_cfg_err;
  logic [DIV_WIDTH-1:0] r_tx_cnt;
  logic                 r_tx_tick;
  logic [DIV_WIDTH-1:0] r_rx_cnt;
  logic                 r_rx_mid_tick;
  logic [DIV_WIDTH-1:0] r_os_cnt;
  logic                 r_os_hit;
  logic                 r_os_tick;

  logic                 w_tx_run;
  logic                 w_rx_run;
  logic                 w_tx_count;
  logic                 w_rx_count;
  logic [DIV_WIDTH-1:0] w_div_last;
  logic [DIV_WIDTH-1:0] w_div_half;
  logic [DIV_WIDTH-1:0] w_div_clamped;
  logic [DIV_WIDTH-1:0] w_os_raw;
  logic [DIV_WIDTH-1:0] w_os_last;

  assign w_tx_run      = (r_tx_state == RUN);
  assign w_rx_run      = (r_rx_state == RUN);
  // A counter advances only while it stays in RUN; the edge that leaves
  // RUN zeroes it so the next frame always starts from a clean phase.
  assign w_tx_count    = w_tx_run && (w_tx_state_next == RUN);
  assign w_rx_count    = w_rx_run && (w_rx_state_next == RUN);
  assign w_div_last    = r_div - DIV_WIDTH'(1);
  assign w_div_half    = r_div >> 1;
  assign w_div_clamped = (bus.cfg_div < DIV_MIN) ? DIV_MIN : bus.cfg_div;
  assign w_os_raw      = r_div >> OS_SHIFT;
  assign w_os_last     = (w_os_raw == '0) ? '0 : (w_os_raw - DIV_WIDTH'(1));

  assign bus.div_q       = r_div;
  assign bus.cfg_err     = r_cfg_err;
  assign bus.tx_busy     = w_tx_run;
  assign bus.rx_busy     = w_rx_run;
  assign bus.tx_tick     = r_tx_tick;
  assign bus.rx_mid_tick = r_rx_mid_tick;
  assign bus.rx_os_tick  = r_os_tick;

  // Channel state registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_rx_state <= IDLE;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_rx_state <= w_rx_state_next;
    end
  end

  // TX next state: in RUN done has priority, in IDLE start has priority.
  always_comb begin
    w_tx_state_next = r_tx_state;
    case (r_tx_state)
      IDLE:    if (bus.tx_start) w_tx_state_next = RUN;
      RUN:     if (bus.tx_done)  w_tx_state_next = IDLE;
      default: w_tx_state_next = IDLE;
    endcase
  end

  // RX next state, same priority rules as TX.
  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      IDLE:    if (bus.rx_start) w_rx_state_next = RUN;
      RUN:     if (bus.rx_done)  w_rx_state_next = IDLE;
      default: w_rx_state_next = IDLE;
    endcase
  end

  // Divisor register: writes land only while both channels are idle,
  // otherwise the attempt is dropped and remembered in the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= DIV_RST;
      r_cfg_err <= 1'b0;
    end else if (bus.cfg_div_we) begin
      if (!w_tx_run && !w_rx_run) begin
        r_div <= w_div_clamped;
      end else begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  // TX bit counter and its strobe, which fires when the count reaches 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_cnt  <= '0;
      r_tx_tick <= 1'b0;
    end else begin
      if (!w_tx_count || (r_tx_cnt == w_div_last)) begin
        r_tx_cnt <= '0;
      end else begin
        r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
      end
      r_tx_tick <= w_tx_run && (r_tx_cnt == DIV_WIDTH'(1));
    end
  end

  // RX bit counter and the strobe at the middle of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt      <= '0;
      r_rx_mid_tick <= 1'b0;
    end else begin
      if (!w_rx_count || (r_rx_cnt == w_div_last)) begin
        r_rx_cnt <= '0;
      end else begin
        r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
      end
      r_rx_mid_tick <= w_rx_run && (r_rx_cnt == w_div_half);
    end
  end

  // RX oversample counter; the hit is staged once more so the first
  // strobe lands two cycles after start, and gated so it dies with RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_os_cnt  <= '0;
      r_os_hit  <= 1'b0;
      r_os_tick <= 1'b0;
    end else begin
      if (!w_rx_count || (r_os_cnt >= w_os_last)) begin
        r_os_cnt <= '0;
      end else begin
        r_os_cnt <= r_os_cnt + DIV_WIDTH'(1);
      end
      r_os_hit  <= w_rx_run && (r_os_cnt == '0);
      r_os_tick <= r_os_hit && w_rx_run;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed timing scenarios plus
// randomized frames compared against an arithmetic timing model.
module tb_uart_baud_gen;

  localparam int DW  = 16;
  localparam int OVS = 4;
  localparam int DIV_RESET = 1_000_000 / 100_000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_baud_gen_if #(.DIV_WIDTH(DW)) bus ();

  uart_baud_gen #(
    .CLK_FRE   (1_000_000),
    .BAUD_RATE (100_000),
    .OVERSAMPLE(OVS),
    .DIV_WIDTH (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Timing model: start sampled at edge k, done at edge m, divisor d.
  // Values are the level seen just after edge t.
  function automatic bit expTx(int t, int k, int m, int d);
    return (t >= k + 2) && (t <= m) && (((t - k - 2) % d) == 0);
  endfunction

  function automatic bit expMid(int t, int k, int m, int d);
    return (t >= k + 1 + d / 2) && (t <= m) && (((t - k - 1 - d / 2) % d) == 0);
  endfunction

  function automatic bit expOs(int t, int k, int m, int d);
    int os;
    os = d / OVS;
    if (os < 1) os = 1;
    return (t >= k + 2) && (t <= m) && (((t - k - 2) % os) == 0);
  endfunction

  function automatic bit expBusy(int t, int k, int m);
    return (t >= k) && (t < m);
  endfunction

  // One clock edge, then settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeDiv(input int value);
    bus.cfg_div_we = 1'b1;
    bus.cfg_div    = DW'(value);
    tick();
    bus.cfg_div_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1;
    tick();
    got = {bus.tx_tick, bus.tx_busy, bus.rx_mid_tick, bus.rx_os_tick, bus.rx_busy};
    checks++;
    if (got !== 5'b0 || bus.div_q !== DW'(DIV_RESET) || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got=%05b/%0d/%0b exp=00000/%0d/0",
               got, bus.div_q, bus.cfg_err, DIV_RESET);
    end
    tick();
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      got = {bus.tx_tick, bus.tx_busy, bus.rx_mid_tick, bus.rx_os_tick, bus.rx_busy};
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("[TB] FAIL idle_outputs t=%0d got=%05b exp=00000", t, got);
      end
    end
    checks++;
    if (bus.div_q !== DW'(DIV_RESET) || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_cfg got=%0d/%0b exp=%0d/0", bus.div_q, bus.cfg_err, DIV_RESET);
    end
  endtask

  task automatic test_tx_timing();
    logic [4:0] got, exp;
    for (int t = 0; t <= 50; t++) begin
      bus.tx_start = (t == 0);
      bus.tx_done  = (t == 35);
      tick();
      got = {bus.tx_tick, bus.tx_busy, bus.rx_mid_tick, bus.rx_os_tick, bus.rx_busy};
      exp = {(t == 2 || t == 12 || t == 22 || t == 32), (t < 35), 3'b000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL tx_timing t=%0d got=%05b exp=%05b", t, got, exp);
      end
    end
    bus.tx_start = 1'b0;
    bus.tx_done  = 1'b0;
  endtask

  task automatic test_rx_timing();
    logic [4:0] got, exp;
    for (int t = 0; t <= 40; t++) begin
      bus.rx_start = (t == 0);
      bus.rx_done  = (t == 30);
      tick();
      got = {bus.tx_tick, bus.tx_busy, bus.rx_mid_tick, bus.rx_os_tick, bus.rx_busy};
      exp = {2'b00, (t == 6 || t == 16 || t == 26),
             (t >= 2 && t <= 30 && (t % 2) == 0), (t < 30)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL rx_timing t=%0d got=%05b exp=%05b", t, got, exp);
      end
    end
    bus.rx_start = 1'b0;
    bus.rx_done  = 1'b0;
  endtask

  task automatic test_div_write();
    logic [1:0] got, exp;
    writeDiv(20);
    checks++;
    if (bus.div_q !== DW'(20) || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_write20 got=%0d/%0b exp=20/0", bus.div_q, bus.cfg_err);
    end
    for (int t = 0; t <= 55; t++) begin
      bus.tx_start = (t == 0);
      bus.tx_done  = (t == 50);
      tick();
      got = {bus.tx_tick, bus.tx_busy};
      exp = {expTx(t, 0, 50, 20), expBusy(t, 0, 50)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL tx_div20 t=%0d got=%02b exp=%02b", t, got, exp);
      end
    end
    bus.tx_start = 1'b0;
    bus.tx_done  = 1'b0;
    writeDiv(2);
    checks++;
    if (bus.div_q !== DW'(4)) begin
      errors++;
      $display("[TB] FAIL div_clamp got=%0d exp=4", bus.div_q);
    end
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    tick();
    writeDiv(7);
    checks++;
    if (bus.div_q !== DW'(4) || bus.cfg_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_busy_reject got=%0d/%0b exp=4/1", bus.div_q, bus.cfg_err);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    writeDiv(33);
    checks++;
    if (bus.div_q !== DW'(33) || bus.cfg_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky got=%0d/%0b exp=33/1", bus.div_q, bus.cfg_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.div_q !== DW'(DIV_RESET) || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear got=%0d/%0b exp=%0d/0", bus.div_q, bus.cfg_err, DIV_RESET);
    end
  endtask

  task automatic test_simultaneous_reset();
    logic [4:0] got, exp;
    for (int t = 0; t <= 26; t++) begin
      bus.tx_start = (t == 0);
      bus.rx_start = (t == 0);
      rst          = (t == 25);
      tick();
      got = {bus.tx_tick, bus.tx_busy, bus.rx_mid_tick, bus.rx_os_tick, bus.rx_busy};
      if (t < 25) begin
        exp = {expTx(t, 0, 1000, DIV_RESET), 1'b1, expMid(t, 0, 1000, DIV_RESET),
               expOs(t, 0, 1000, DIV_RESET), 1'b1};
      end else begin
        exp = 5'b00000;
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL simul_reset t=%0d got=%05b exp=%05b", t, got, exp);
      end
    end
    rst          = 1'b0;
    bus.tx_start = 1'b0;
    bus.rx_start = 1'b0;
  endtask

  task automatic test_done_start_same();
    logic [4:0] got, exp;
    for (int t = 0; t <= 60; t++) begin
      bus.tx_start = (t == 0 || t == 15 || t == 30);
      bus.tx_done  = (t == 15 || t == 50);
      bus.rx_start = bus.tx_start;
      bus.rx_done  = bus.tx_done;
      tick();
      got = {bus.tx_tick, bus.tx_busy, bus.rx_mid_tick, bus.rx_os_tick, bus.rx_busy};
      exp = {expTx(t, 0, 15, 10) || expTx(t, 30, 50, 10),
             expBusy(t, 0, 15) || expBusy(t, 30, 50),
             expMid(t, 0, 15, 10) || expMid(t, 30, 50, 10),
             expOs(t, 0, 15, 10) || expOs(t, 30, 50, 10),
             expBusy(t, 0, 15) || expBusy(t, 30, 50)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL done_start_same t=%0d got=%05b exp=%05b", t, got, exp);
      end
    end
    bus.tx_start = 1'b0;
    bus.tx_done  = 1'b0;
    bus.rx_start = 1'b0;
    bus.rx_done  = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] got, exp;
    int value, div, txS, txD, rxS, rxD, last;
    for (int iter = 0; iter < 6; iter++) begin
      value = $urandom_range(0, 48);
      div   = (value < 4) ? 4 : value;
      writeDiv(value);
      checks++;
      if (bus.div_q !== DW'(div) || bus.cfg_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_div it=%0d got=%0d/%0b exp=%0d/0",
                 iter, bus.div_q, bus.cfg_err, div);
      end
      txS  = $urandom_range(0, 6);
      txD  = txS + $urandom_range(1, 3 * div);
      rxS  = $urandom_range(0, 6);
      rxD  = rxS + $urandom_range(1, 3 * div);
      last = ((txD > rxD) ? txD : rxD) + 4;
      for (int t = 0; t <= last; t++) begin
        bus.tx_start = (t == txS) || (t > txS && t < txD && $urandom_range(0, 7) == 0);
        bus.tx_done  = (t == txD) || ((t < txS || t > txD) && $urandom_range(0, 3) == 0);
        bus.rx_start = (t == rxS) || (t > rxS && t < rxD && $urandom_range(0, 7) == 0);
        bus.rx_done  = (t == rxD) || ((t < rxS || t > rxD) && $urandom_range(0, 3) == 0);
        tick();
        got = {bus.tx_tick, bus.tx_busy, bus.rx_mid_tick, bus.rx_os_tick, bus.rx_busy};
        exp = {expTx(t, txS, txD, div), expBusy(t, txS, txD),
               expMid(t, rxS, rxD, div), expOs(t, rxS, rxD, div), expBusy(t, rxS, rxD)};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL rand_frame it=%0d div=%0d t=%0d got=%05b exp=%05b",
                   iter, div, t, got, exp);
        end
      end
      bus.tx_start = 1'b0;
      bus.tx_done  = 1'b0;
      bus.rx_start = 1'b0;
      bus.rx_done  = 1'b0;
    end
  endtask

  // Scenario sequence and final summary.
  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.cfg_div_we = 1'b0;
    bus.cfg_div    = '0;
    bus.tx_start   = 1'b0;
    bus.tx_done    = 1'b0;
    bus.rx_start   = 1'b0;
    bus.rx_done    = 1'b0;
    test_reset();
    test_tx_timing();
    test_rx_timing();
    test_div_write();
    test_simultaneous_reset();
    test_done_start_same();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
